// File: rtl/round_key_rbuf.sv
// Round-key replay buffer: captures the NR+1 expanded round keys once and replays them
// forward (encrypt) or reverse (decrypt) to the round pipeline with valid/ready handshake.
module round_key_rbuf #(
   parameter int KEY_S = 128,
   parameter int NR    = 10,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             w_e,
   input  logic [KEY_S-1:0] key_in,
   input  logic             rd_start,
   input  logic             dir,
   input  logic             out_ready,
   output logic [KEY_S-1:0] rd_key,
   output logic             out_valid,
   output logic             out_last,
   output logic             full,
   output logic             busy
);

   typedef enum logic [1:0] {EMPTY, FILL, FULL, READ} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
   localparam logic [IDX_W-1:0] ZERO_IDX = '0;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
   logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
   logic             dir_r, dir_nxt;
   logic             mem_we;
   logic             at_end;
   logic [KEY_S-1:0] mem [NR+1];

   // Final index of the current replay depends on the direction latched at rd_start.
   assign at_end = (rd_idx == (dir_r ? ZERO_IDX : LAST_IDX));

   always_comb begin
      state_nxt  = state;
      wr_idx_nxt = wr_idx;
      rd_idx_nxt = rd_idx;
      dir_nxt    = dir_r;
      mem_we     = 1'b0;
      if (clear) begin
         state_nxt  = EMPTY;
         wr_idx_nxt = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (w_e) begin
                  mem_we     = 1'b1;
                  wr_idx_nxt = IDX_W'(1);
                  state_nxt  = FILL;
               end
            end
            FILL: begin
               if (w_e) begin
                  mem_we     = 1'b1;
                  wr_idx_nxt = wr_idx + 1'b1;
                  if (wr_idx == LAST_IDX) state_nxt = FULL;
               end
            end
            FULL: begin
               if (rd_start) begin
                  dir_nxt    = dir;
                  rd_idx_nxt = dir ? LAST_IDX : ZERO_IDX;
                  state_nxt  = READ;
               end
            end
            READ: begin
               if (out_ready) begin
                  if (at_end) state_nxt  = FULL;
                  else        rd_idx_nxt = dir_r ? (rd_idx - 1'b1) : (rd_idx + 1'b1);
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= EMPTY;
         wr_idx <= '0;
         rd_idx <= '0;
         dir_r  <= 1'b0;
      end else begin
         state  <= state_nxt;
         wr_idx <= wr_idx_nxt;
         rd_idx <= rd_idx_nxt;
         dir_r  <= dir_nxt;
      end
   end

   // Key storage carries no reset; it is only read once every entry has been written.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_idx] <= key_in;
   end

   // Outputs decode from registered state only, so a stalled beat stays stable.
   assign out_valid = (state == READ);
   assign busy      = (state == READ);
   assign full      = (state == FULL) || (state == READ);
   assign out_last  = (state == READ) && at_end;
   assign rd_key    = (state == READ) ? mem[rd_idx] : '0;

endmodule
